fp_add_sequencer: RTL



---
 rtl/fp_add_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision adder: unpack, serial align, add,
// serial normalise, repack. Truncating rounding, denormals flushed to zero.
module fp_add_sequencer #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [EXP_W+MANT_W:0]    i_a,
    input  logic [EXP_W+MANT_W:0]    i_b,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [EXP_W+MANT_W:0]    o_result,
    output logic                     o_busy,
    output logic [2:0]               o_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready and o_result is stable while o_valid.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPECIAL = 3'd1,
        ALIGN   = 3'd2,
        ADD     = 3'd3,
        NORM    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] SAT_D    = EXP_W'(MANT_W + 1);
    localparam logic [EXP_W+MANT_W:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

    state_t state_q, state_d;

    logic [EXP_W+MANT_W:0] a_q, b_q, result_q;
    logic                  sign_big_q, sign_small_q, res_sign_q;
    logic [EXP_W-1:0]      exp_big_q, d_q;
    logic [MANT_W:0]       mant_big_q, mant_small_q;
    logic [MANT_W+1:0]     sum_q;

    logic [EXP_W-1:0] exp_a, exp_b, exp_aq, exp_bq;
    logic [MANT_W:0]  mant_a, mant_b;
    logic             accept, a_big, a_nan, b_nan, a_inf, b_inf;

    assign exp_a  = i_a[MANT_W +: EXP_W];
    assign exp_b  = i_b[MANT_W +: EXP_W];
    assign mant_a = (exp_a == '0) ? '0 : {1'b1, i_a[MANT_W-1:0]};
    assign mant_b = (exp_b == '0) ? '0 : {1'b1, i_b[MANT_W-1:0]};
    assign a_big  = (exp_a >= exp_b);
    assign accept = (state_q == IDLE) && i_valid;

    assign exp_aq = a_q[MANT_W +: EXP_W];
    assign exp_bq = b_q[MANT_W +: EXP_W];
    assign a_nan  = (exp_aq == EXP_ONES) && (a_q[MANT_W-1:0] != '0);
    assign b_nan  = (exp_bq == EXP_ONES) && (b_q[MANT_W-1:0] != '0);
    assign a_inf  = (exp_aq == EXP_ONES) && (a_q[MANT_W-1:0] == '0);
    assign b_inf  = (exp_bq == EXP_ONES) && (b_q[MANT_W-1:0] == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid)
                    state_d = (exp_a == EXP_ONES || exp_b == EXP_ONES) ? SPECIAL : ALIGN;
            end
            SPECIAL: state_d = DONE;
            ALIGN: begin
                if (d_q > SAT_D || d_q <= EXP_ONE) state_d = ADD;
            end
            ADD: begin
                if (sign_big_q != sign_small_q && mant_big_q == mant_small_q) state_d = DONE;
                else                                                         state_d = NORM;
            end
            NORM: begin
                // Stay only while another left shift will still be needed.
                if (sum_q[MANT_W+1] || sum_q[MANT_W] || exp_big_q == EXP_ONE || sum_q[MANT_W-1])
                    state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_result = result_q;
    assign o_state  = state_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q <= '0; b_q <= '0; result_q <= '0;
            sign_big_q <= 1'b0; sign_small_q <= 1'b0; res_sign_q <= 1'b0;
            exp_big_q <= '0; d_q <= '0;
            mant_big_q <= '0; mant_small_q <= '0; sum_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q <= i_a;
                    b_q <= i_b;
                    if (a_big) begin
                        sign_big_q   <= i_a[EXP_W+MANT_W];
                        sign_small_q <= i_b[EXP_W+MANT_W];
                        exp_big_q    <= exp_a;
                        mant_big_q   <= mant_a;
                        mant_small_q <= mant_b;
                        d_q          <= exp_a - exp_b;
                    end else begin
                        sign_big_q   <= i_b[EXP_W+MANT_W];
                        sign_small_q <= i_a[EXP_W+MANT_W];
                        exp_big_q    <= exp_b;
                        mant_big_q   <= mant_b;
                        mant_small_q <= mant_a;
                        d_q          <= exp_b - exp_a;
                    end
                end
                SPECIAL: begin
                    if (a_nan || b_nan || (a_inf && b_inf && a_q[EXP_W+MANT_W] != b_q[EXP_W+MANT_W]))
                        result_q <= QNAN;
                    else if (a_inf)
                        result_q <= {a_q[EXP_W+MANT_W], EXP_ONES, {MANT_W{1'b0}}};
                    else
                        result_q <= {b_q[EXP_W+MANT_W], EXP_ONES, {MANT_W{1'b0}}};
                end
                ALIGN: begin
                    if (d_q > SAT_D) begin
                        mant_small_q <= '0;
                        d_q          <= '0;
                    end else if (d_q != '0) begin
                        mant_small_q <= mant_small_q >> 1;
                        d_q          <= d_q - EXP_ONE;
                    end
                end
                ADD: begin
                    if (sign_big_q == sign_small_q) begin
                        sum_q      <= {1'b0, mant_big_q} + {1'b0, mant_small_q};
                        res_sign_q <= sign_big_q;
                    end else if (mant_big_q > mant_small_q) begin
                        sum_q      <= {1'b0, mant_big_q} - {1'b0, mant_small_q};
                        res_sign_q <= sign_big_q;
                    end else if (mant_small_q > mant_big_q) begin
                        sum_q      <= {1'b0, mant_small_q} - {1'b0, mant_big_q};
                        res_sign_q <= sign_small_q;
                    end else begin
                        result_q   <= '0;
                    end
                end
                NORM: begin
                    if (sum_q[MANT_W+1]) begin
                        if (exp_big_q + EXP_ONE == EXP_ONES)
                            result_q <= {res_sign_q, EXP_ONES, {MANT_W{1'b0}}};
                        else
                            result_q <= {res_sign_q, exp_big_q + EXP_ONE, sum_q[MANT_W:1]};
                    end else if (!sum_q[MANT_W]) begin
                        if (exp_big_q == EXP_ONE) begin
                            result_q <= '0;
                        end else begin
                            sum_q     <= sum_q << 1;
                            exp_big_q <= exp_big_q - EXP_ONE;
                            if (sum_q[MANT_W-1])
                                result_q <= {res_sign_q, exp_big_q - EXP_ONE, sum_q[MANT_W-2:0], 1'b0};
                        end
                    end else begin
                        result_q <= {res_sign_q, exp_big_q, sum_q[MANT_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
